// File: rtl/inta_sequencer.sv
// INTA handshake sequencer: tracks CPU acknowledge pulses, latches the serviced
// level, and produces the vector bytes, ISR set strobe and cascade window.
module inta_sequencer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       INTA_n,
  input  logic       SNGL,
  input  logic       Master_Slave,
  input  logic [2:0] ID,
  input  logic       uPM,
  input  logic [7:0] slave_map,
  input  logic [2:0] my_id,
  input  logic       int_req,
  input  logic [2:0] int_level,
  input  logic [4:0] vector_base,
  input  logic [7:0] addr_hi,
  output logic       INT,
  output logic       INTA_2,
  output logic [2:0] cas_level,
  output logic       freeze,
  output logic       isr_set,
  output logic [2:0] isr_level,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       abort_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, PULSE, GAP} state_t;

  state_t        state;
  logic [1:0]    pcnt;
  logic [TW-1:0] tcnt;
  logic          inta_s1, inta_s2, inta_q;
  logic          upm_l, sngl_l, ms_l, sel, spur;

  logic          inta_fall, inta_rise, busy, first, tmo, seq_end;
  logic          upm_e, sngl_e, ms_e, spur_e, sel_e, slv, mst, rights;
  logic [2:0]    lvl_e;
  logic [1:0]    pnext, plast;
  logic [7:0]    vec, byte_n;
  logic          has_byte, oe_n, set_n;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {inta_s1, inta_s2, inta_q} <= 3'b111;
    else        {inta_s1, inta_s2, inta_q} <= {INTA_n, inta_s1, inta_s2};

  assign inta_fall = inta_q & ~inta_s2;
  assign inta_rise = ~inta_q & inta_s2;
  assign busy      = (state == PULSE) || (state == GAP);

  // On the first fall the live mode inputs are the ones being latched,
  // so use them directly; afterwards only the latched copies matter.
  assign first  = (state == REQ) && inta_fall;
  assign upm_e  = first ? uPM          : upm_l;
  assign sngl_e = first ? SNGL         : sngl_l;
  assign ms_e   = first ? Master_Slave : ms_l;
  assign spur_e = first ? ~int_req     : spur;
  assign lvl_e  = first ? (int_req ? int_level : 3'd7) : isr_level;
  assign pnext  = first ? 2'd1 : pcnt + 2'd1;
  assign plast  = upm_e ? 2'd2 : 2'd3;
  assign sel_e  = (pnext == 2'd2) ? (ID == my_id) : sel;

  assign slv    = ~sngl_e & ~ms_e;
  assign mst    = ~sngl_e & ms_e;
  assign rights = sngl_e | (mst & ~slave_map[lvl_e]) | (slv & sel_e);
  assign vec    = {vector_base, lvl_e};

  always_comb begin
    byte_n   = 8'h00;
    has_byte = 1'b0;
    if (upm_e) begin
      has_byte = (pnext == 2'd2);
      byte_n   = vec;
    end else begin
      case (pnext)
        2'd1:    begin has_byte = ~slv; byte_n = 8'hCD;   end
        2'd2:    begin has_byte = 1'b1; byte_n = vec;     end
        2'd3:    begin has_byte = 1'b1; byte_n = addr_hi; end
        default: ;
      endcase
    end
  end

  assign oe_n    = has_byte & rights;
  assign set_n   = ~spur_e & (slv ? (sel_e && (pnext == plast)) : (pnext == 2'd1));
  assign tmo     = busy && !(inta_fall || inta_rise) && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign seq_end = (state == PULSE) && inta_rise && (pcnt == plast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pcnt      <= 2'd0;
      tcnt      <= '0;
      upm_l     <= 1'b0;
      sngl_l    <= 1'b0;
      ms_l      <= 1'b0;
      sel       <= 1'b0;
      spur      <= 1'b0;
      INT       <= 1'b0;
      INTA_2    <= 1'b0;
      cas_level <= 3'd0;
      freeze    <= 1'b0;
      isr_set   <= 1'b0;
      isr_level <= 3'd0;
      data_out  <= 8'h00;
      data_oe   <= 1'b0;
      abort_err <= 1'b0;
    end else begin
      isr_set   <= 1'b0;
      abort_err <= 1'b0;
      if (seq_end || tmo) begin
        // Normal completion and timeout both unwind to IDLE; only the
        // timeout flags an error. A prior isr_set stays issued.
        state     <= IDLE;
        pcnt      <= 2'd0;
        tcnt      <= '0;
        sel       <= 1'b0;
        spur      <= 1'b0;
        INT       <= 1'b0;
        INTA_2    <= 1'b0;
        cas_level <= 3'd0;
        freeze    <= 1'b0;
        isr_level <= 3'd0;
        data_out  <= 8'h00;
        data_oe   <= 1'b0;
        abort_err <= tmo;
      end else begin
        case (state)
          IDLE: if (int_req) begin
            state <= REQ;
            INT   <= 1'b1;
          end
          REQ: if (inta_fall) begin
            state     <= PULSE;
            pcnt      <= 2'd1;
            tcnt      <= '0;
            upm_l     <= uPM;
            sngl_l    <= SNGL;
            ms_l      <= Master_Slave;
            spur      <= ~int_req;
            sel       <= 1'b0;
            isr_level <= lvl_e;
            cas_level <= lvl_e;
            freeze    <= 1'b1;
            INTA_2    <= ~SNGL & Master_Slave;
            isr_set   <= set_n;
            data_oe   <= oe_n;
            data_out  <= oe_n ? byte_n : 8'h00;
          end else if (!int_req) begin
            state <= IDLE;
            INT   <= 1'b0;
          end
          PULSE: if (inta_rise) begin
            state    <= GAP;
            tcnt     <= '0;
            data_oe  <= 1'b0;
            data_out <= 8'h00;
          end else begin
            tcnt <= inta_fall ? '0 : tcnt + TW'(1);
          end
          GAP: if (inta_fall) begin
            state    <= PULSE;
            pcnt     <= pnext;
            tcnt     <= '0;
            isr_set  <= set_n;
            data_oe  <= oe_n;
            data_out <= oe_n ? byte_n : 8'h00;
            if (pnext == 2'd2) sel <= sel_e;
            if (pnext == plast) INT <= 1'b0;
          end else begin
            tcnt <= inta_rise ? '0 : tcnt + TW'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: directed vector table, randomized sequences against
// a rule-level model, plus timeout / reset / withdrawn-request corner cases.
module tb_inta_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       INTA_n = 1'b1;
  logic       SNGL = 1'b1, Master_Slave = 1'b0, uPM = 1'b1, int_req = 1'b0;
  logic [2:0] ID = 3'd0, my_id = 3'd0, int_level = 3'd0;
  logic [7:0] slave_map = 8'h00, addr_hi = 8'h00;
  logic [4:0] vector_base = 5'h00;
  logic       INT, INTA_2, freeze, isr_set, data_oe, abort_err;
  logic [2:0] cas_level, isr_level;
  logic [7:0] data_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inta_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .INTA_n(INTA_n), .SNGL(SNGL), .Master_Slave(Master_Slave),
    .ID(ID), .uPM(uPM), .slave_map(slave_map), .my_id(my_id), .int_req(int_req),
    .int_level(int_level), .vector_base(vector_base), .addr_hi(addr_hi),
    .INT(INT), .INTA_2(INTA_2), .cas_level(cas_level), .freeze(freeze),
    .isr_set(isr_set), .isr_level(isr_level), .data_out(data_out),
    .data_oe(data_oe), .abort_err(abort_err)
  );

  typedef struct packed {
    logic       sngl, ms, upm, req;
    logic [2:0] lvl, my_id, id;
    logic [7:0] map;
    logic [4:0] base;
    logic [7:0] ahi;
  } cfg_t;

  // oe[p-1] / bytes[p-1] describe pulse p; set_p = pulse carrying isr_set (0 = none)
  typedef struct packed {
    logic [2:0]      lvl;
    logic [1:0]      set_p;
    logic            inta2;
    logic [2:0]      oe;
    logic [2:0][7:0] bytes;
  } exp_t;

  typedef struct packed {
    cfg_t c;
    exp_t e;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: derive what the CPU should see on each pulse from the mode rules.
  function automatic exp_t model(input cfg_t c);
    exp_t e;
    int   np;
    bit   single, master, slave, sel, drive, has;
    logic [7:0] b;
    e      = '0;
    np     = c.upm ? 2 : 3;
    single = c.sngl;
    master = !c.sngl && c.ms;
    slave  = !c.sngl && !c.ms;
    sel    = (c.id == c.my_id);
    e.lvl  = c.req ? c.lvl : 3'd7;
    e.inta2 = master;
    if (!c.req)     e.set_p = 2'd0;
    else if (slave) e.set_p = sel ? 2'(np) : 2'd0;
    else            e.set_p = 2'd1;
    for (int p = 1; p <= np; p++) begin
      if (c.upm) begin
        has = (p == 2);
        b   = {c.base, e.lvl};
      end else begin
        has = (p != 1) || !slave;
        b   = (p == 1) ? 8'hCD : (p == 2) ? {c.base, e.lvl} : c.ahi;
      end
      drive = single || (master && !c.map[e.lvl]) || (slave && sel && p >= 2);
      e.oe[p-1]    = has && drive;
      e.bytes[p-1] = b;
    end
    return e;
  endfunction

  task automatic run_seq(input cfg_t c, input exp_t e, input string nm);
    int np;
    np           = c.upm ? 2 : 3;
    SNGL         = c.sngl;
    Master_Slave = c.ms;
    uPM          = c.upm;
    slave_map    = c.map;
    my_id        = c.my_id;
    ID           = ~c.id;
    int_level    = c.lvl;
    vector_base  = c.base;
    addr_hi      = c.ahi;
    int_req      = 1'b1;
    tick(1);
    chk({nm, ".int_req"}, 32'(INT), 32'd1);
    for (int p = 1; p <= np; p++) begin
      if (p == 2) ID = c.id;
      INTA_n = 1'b0;
      tick(2);
      if (p == 1 && !c.req) int_req = 1'b0;
      tick(1);
      chk($sformatf("%s.p%0d.isr_set", nm, p), 32'(isr_set), 32'(e.set_p == 2'(p)));
      chk($sformatf("%s.p%0d.data_oe", nm, p), 32'(data_oe), 32'(e.oe[p-1]));
      chk($sformatf("%s.p%0d.data_out", nm, p), 32'(data_out), e.oe[p-1] ? 32'(e.bytes[p-1]) : 32'd0);
      chk($sformatf("%s.p%0d.INT", nm, p), 32'(INT), 32'(p != np));
      chk($sformatf("%s.p%0d.INTA_2", nm, p), 32'(INTA_2), 32'(e.inta2));
      chk($sformatf("%s.p%0d.freeze", nm, p), 32'(freeze), 32'd1);
      chk($sformatf("%s.p%0d.isr_level", nm, p), 32'(isr_level), 32'(e.lvl));
      chk($sformatf("%s.p%0d.cas_level", nm, p), 32'(cas_level), 32'(e.lvl));
      if (p == 1) begin
        // everything below must be ignored once pulse 1 has latched the mode
        int_req      = 1'b0;
        int_level    = 3'($urandom);
        uPM          = 1'($urandom);
        SNGL         = 1'($urandom);
        Master_Slave = 1'($urandom);
      end
      if (p == 2) ID = c.id ^ 3'd5;
      tick(1);
      chk($sformatf("%s.p%0d.isr_set_1cyc", nm, p), 32'(isr_set), 32'd0);
      tick(1);
      INTA_n = 1'b1;
      tick(3);
      chk($sformatf("%s.p%0d.gap_oe", nm, p), 32'(data_oe), 32'd0);
      if (p == np) begin
        chk({nm, ".end.freeze"}, 32'(freeze), 32'd0);
        chk({nm, ".end.INTA_2"}, 32'(INTA_2), 32'd0);
        chk({nm, ".end.INT"}, 32'(INT), 32'd0);
      end
      tick(1);
    end
  endtask

  vec_t tbl[9];

  initial begin
    cfg_t c;
    // cfg: sngl ms upm req lvl my_id id map base ahi | exp: lvl set_p inta2 oe bytes{p3,p2,p1}
    tbl[0] = '{'{1'b1,1'b0,1'b1,1'b1,3'd5,3'd0,3'd0,8'h00,5'h08,8'h00}, '{3'd5,2'd1,1'b0,3'b010,{8'h00,8'h45,8'h00}}};
    tbl[1] = '{'{1'b0,1'b1,1'b1,1'b1,3'd2,3'd0,3'd0,8'h04,5'h08,8'h00}, '{3'd2,2'd1,1'b1,3'b000,24'h0}};
    tbl[2] = '{'{1'b0,1'b0,1'b1,1'b1,3'd3,3'd2,3'd2,8'h00,5'h08,8'h00}, '{3'd3,2'd2,1'b0,3'b010,{8'h00,8'h43,8'h00}}};
    tbl[3] = '{'{1'b0,1'b0,1'b1,1'b1,3'd3,3'd2,3'd3,8'h00,5'h08,8'h00}, '{3'd3,2'd0,1'b0,3'b000,24'h0}};
    tbl[4] = '{'{1'b1,1'b0,1'b0,1'b1,3'd1,3'd0,3'd0,8'h00,5'h10,8'h3A}, '{3'd1,2'd1,1'b0,3'b111,{8'h3A,8'h81,8'hCD}}};
    tbl[5] = '{'{1'b1,1'b0,1'b1,1'b0,3'd4,3'd0,3'd0,8'h00,5'h08,8'h00}, '{3'd7,2'd0,1'b0,3'b010,{8'h00,8'h47,8'h00}}};
    tbl[6] = '{'{1'b0,1'b1,1'b0,1'b1,3'd5,3'd0,3'd0,8'h04,5'h10,8'h12}, '{3'd5,2'd1,1'b1,3'b111,{8'h12,8'h85,8'hCD}}};
    tbl[7] = '{'{1'b0,1'b0,1'b0,1'b1,3'd0,3'd6,3'd6,8'h00,5'h1F,8'hC3}, '{3'd0,2'd3,1'b0,3'b110,{8'hC3,8'hF8,8'h00}}};
    tbl[8] = '{'{1'b0,1'b1,1'b0,1'b0,3'd2,3'd0,3'd0,8'h80,5'h10,8'h55}, '{3'd7,2'd0,1'b1,3'b000,24'h0}};

    #3;
    chk("reset.INT", 32'(INT), 32'd0);
    chk("reset.freeze", 32'(freeze), 32'd0);
    chk("reset.data_oe", 32'(data_oe), 32'd0);
    chk("reset.isr_level", 32'(isr_level), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    for (int i = 0; i < 9; i++) run_seq(tbl[i].c, tbl[i].e, $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      c.sngl  = 1'($urandom);
      c.ms    = 1'($urandom);
      c.upm   = 1'($urandom);
      c.req   = ($urandom_range(0, 7) != 0);
      c.lvl   = 3'($urandom);
      c.my_id = 3'($urandom);
      c.id    = ($urandom_range(0, 1) == 1) ? c.my_id : 3'($urandom);
      c.map   = 8'($urandom);
      c.base  = 5'($urandom);
      c.ahi   = 8'($urandom);
      run_seq(c, model(c), $sformatf("rnd%0d", i));
    end

    // request withdrawn before any acknowledge; a stray INTA must then do nothing
    int_req = 1'b1;
    tick(1);
    chk("withdraw.INT_up", 32'(INT), 32'd1);
    int_req = 1'b0;
    tick(1);
    chk("withdraw.INT_down", 32'(INT), 32'd0);
    INTA_n = 1'b0;
    tick(4);
    chk("stray.freeze", 32'(freeze), 32'd0);
    chk("stray.isr_set", 32'(isr_set), 32'd0);
    INTA_n = 1'b1;
    tick(4);

    // INTA held low past the timeout
    SNGL = 1'b1; uPM = 1'b1; int_level = 3'd6; vector_base = 5'h02;
    int_req = 1'b1;
    tick(1);
    INTA_n = 1'b0;
    tick(3);
    chk("tmo.isr_set", 32'(isr_set), 32'd1);
    chk("tmo.freeze", 32'(freeze), 32'd1);
    int_req = 1'b0;
    tick(15);
    chk("tmo.not_yet", 32'(abort_err), 32'd0);
    chk("tmo.still_frozen", 32'(freeze), 32'd1);
    tick(1);
    chk("tmo.abort_err", 32'(abort_err), 32'd1);
    chk("tmo.freeze_clr", 32'(freeze), 32'd0);
    chk("tmo.INT_clr", 32'(INT), 32'd0);
    chk("tmo.level_clr", 32'(isr_level), 32'd0);
    tick(1);
    chk("tmo.abort_1cyc", 32'(abort_err), 32'd0);
    tick(2);
    INTA_n = 1'b1;
    tick(5);
    chk("tmo.late_rise", 32'(freeze), 32'd0);

    // asynchronous reset in the middle of an 8080 pulse 1 (CALL byte on the bus)
    SNGL = 1'b1; uPM = 1'b0; int_level = 3'd3; vector_base = 5'h04; addr_hi = 8'h77;
    int_req = 1'b1;
    tick(1);
    INTA_n = 1'b0;
    tick(3);
    chk("rstmid.pre_oe", 32'(data_oe), 32'd1);
    chk("rstmid.pre_data", 32'(data_out), 32'hCD);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid.INT", 32'(INT), 32'd0);
    chk("rstmid.freeze", 32'(freeze), 32'd0);
    chk("rstmid.data_oe", 32'(data_oe), 32'd0);
    chk("rstmid.data_out", 32'(data_out), 32'd0);
    chk("rstmid.isr_level", 32'(isr_level), 32'd0);
    INTA_n  = 1'b1;
    int_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(5);
    chk("rstmid.after", 32'(INT), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

endmodule
